// File: rtl/spi_instruction_frontend.sv
// SPI mode-0 target that turns a 16-bit host frame into a one-cycle opcode/operand issue and a start strobe,
// and shifts the previously captured execution result back out on MISO. SCLK/CS are oversampled by clk.
module spi_instruction_frontend #(
  parameter int INPUT_DATA_WIDTH  = 4,
  parameter int OUTPUT_DATA_WIDTH = 8,
  parameter int SYNC_STAGES       = 2,
  parameter int START_DELAY       = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           spi_sclk,
  input  logic                           spi_cs_n,
  input  logic                           spi_mosi,
  output logic                           spi_miso,
  input  logic [OUTPUT_DATA_WIDTH-1:0]   cpu_out,
  output logic [2*INPUT_DATA_WIDTH-1:0]  opcode,
  output logic [2*INPUT_DATA_WIDTH-1:0]  operand,
  output logic                           start,
  output logic                           busy,
  output logic                           frame_err
);

  localparam int WORD_W  = 2 * INPUT_DATA_WIDTH;
  localparam int FRAME_W = 4 * INPUT_DATA_WIDTH;
  localparam int CNT_W   = $clog2(FRAME_W + 1);
  localparam int DLY_W   = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;

  typedef enum logic [2:0] {S_IDLE, S_SHIFT, S_ISSUE, S_WAIT, S_DRAIN} state_t;

  state_t state, state_n;

  logic [SYNC_STAGES-1:0]       sclk_sync, cs_sync, mosi_sync;
  logic                         sclk_prev, cs_prev;
  logic                         sclk_s, cs_s, mosi_s;
  logic                         sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic [FRAME_W-1:0]           shift_reg;
  logic [CNT_W-1:0]             bit_cnt;
  logic [DLY_W-1:0]             dly_cnt;
  logic [OUTPUT_DATA_WIDTH-1:0] reply;
  logic                         err_done;

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev;
  assign sclk_fall = ~sclk_s & sclk_prev;
  assign cs_rise   = cs_s & ~cs_prev;
  assign cs_fall   = ~cs_s & cs_prev;

  // Synchronisers reset to 0, so a CS already low at reset release never looks like a fall.
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_sync <= '0;
      cs_sync   <= '0;
      mosi_sync <= '0;
      sclk_prev <= 1'b0;
      cs_prev   <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      sclk_prev <= sclk_s;
      cs_prev   <= cs_s;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
      dly_cnt   <= '0;
      reply     <= '0;
      err_done  <= 1'b0;
    end else begin
      state <= state_n;

      if (state == S_IDLE && cs_fall) begin
        bit_cnt  <= '0;
        err_done <= 1'b0;
      end else if (state == S_SHIFT && sclk_rise && bit_cnt != CNT_W'(FRAME_W)) begin
        shift_reg <= {shift_reg[FRAME_W-2:0], mosi_s};
        bit_cnt   <= bit_cnt + CNT_W'(1);
      end else if (frame_err) begin
        err_done <= 1'b1;
      end

      if (state == S_ISSUE)
        dly_cnt <= '0;
      else if (state == S_WAIT)
        dly_cnt <= dly_cnt + DLY_W'(1);

      // Reply shifts left with zero fill, so MISO naturally reads 0 after the last result bit.
      if (state == S_IDLE && cs_fall)
        reply <= cpu_out;
      else if (cs_rise)
        reply <= '0;
      else if (sclk_fall && !cs_s)
        reply <= {reply[OUTPUT_DATA_WIDTH-2:0], 1'b0};
    end
  end

  assign spi_miso = reply[OUTPUT_DATA_WIDTH-1] & ~cs_s;

  always_comb begin
    state_n   = state;
    opcode    = '0;
    operand   = '0;
    start     = 1'b0;
    busy      = 1'b0;
    frame_err = 1'b0;
    case (state)
      S_IDLE: begin
        if (cs_fall) state_n = S_SHIFT;
      end
      S_SHIFT: begin
        busy = 1'b1;
        if (cs_rise) begin
          frame_err = 1'b1;
          state_n   = S_IDLE;
        end else if (sclk_rise && bit_cnt == CNT_W'(FRAME_W - 1)) begin
          state_n = S_ISSUE;
        end
      end
      S_ISSUE: begin
        busy    = 1'b1;
        opcode  = shift_reg[FRAME_W-1:WORD_W];
        operand = shift_reg[WORD_W-1:0];
        state_n = S_WAIT;
      end
      S_WAIT: begin
        busy = 1'b1;
        if (dly_cnt == DLY_W'(START_DELAY - 1)) begin
          start   = 1'b1;
          state_n = cs_s ? S_IDLE : S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (cs_rise) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
    // Extra SCLK rises after the full frame only flag an error, once, while CS is still low.
    if ((state == S_ISSUE || state == S_WAIT || state == S_DRAIN) && sclk_rise && !cs_s && !err_done)
      frame_err = 1'b1;
  end

endmodule

// File: tb/tb_spi_instruction_frontend.sv
// Randomized self-checking bench for spi_instruction_frontend with a frame-level reference model.
module tb_spi_instruction_frontend;

  localparam int HALF        = 4;
  localparam int START_DELAY = 2;

  logic       clk = 1'b0;
  logic       reset, spi_sclk, spi_cs_n, spi_mosi, spi_miso;
  logic [7:0] cpu_out, opcode, operand;
  logic       start, busy, frame_err;

  spi_instruction_frontend #(
    .INPUT_DATA_WIDTH(4),
    .OUTPUT_DATA_WIDTH(8),
    .SYNC_STAGES(2),
    .START_DELAY(START_DELAY)
  ) dut (
    .clk(clk), .reset(reset), .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .cpu_out(cpu_out), .opcode(opcode), .operand(operand),
    .start(start), .busy(busy), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Observed activity
  logic [15:0] got_q[$];
  int cyc = 0, issue_cyc = 0, start_cnt = 0, err_cnt = 0;
  bit after_start = 0;

  always @(negedge clk) begin
    cyc++;
    if (after_start) check("busy_drop", 32'(busy), 32'd0);
    after_start = 0;
    if (opcode != 8'h00 || operand != 8'h00) begin
      got_q.push_back({opcode, operand});
      issue_cyc = cyc;
    end
    if (frame_err) err_cnt++;
    if (start) begin
      start_cnt++;
      check("start_latency", 32'(cyc - issue_cyc), 32'(START_DELAY));
      check("busy_at_start", 32'(busy), 32'd1);
      after_start = 1;
    end
  end

  // Reference model: frame-level expectations
  logic [15:0] exp_q[$];
  int exp_err = 0;

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clock_bits(input logic [31:0] bits, input int n, input logic [7:0] rep, input bit active);
    for (int i = 0; i < n; i++) begin
      spi_mosi = bits[n-1-i];
      wait_clk(HALF);
      check("miso_bit", 32'(spi_miso), (i < 8) ? 32'(rep[7-i]) : 32'd0);
      if (i < 16) check("busy_in_frame", 32'(busy), 32'(active));
      spi_sclk = 1'b1;
      wait_clk(HALF);
      spi_sclk = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [31:0] bits, input int n, input logic [7:0] cv, input int gap);
    logic [31:0] first;
    cpu_out  = cv;
    spi_cs_n = 1'b0;
    wait_clk(2 * HALF);
    clock_bits(bits, n, cv, 1'b1);
    wait_clk(HALF);
    spi_cs_n = 1'b1;
    if (n >= 16) begin
      first = bits >> (n - 16);
      exp_q.push_back(first[15:0]);
    end
    if (n != 16) exp_err++;
    wait_clk(gap);
  endtask

  task automatic verify();
    wait_clk(30);
    check("miso_cs_high", 32'(spi_miso), 32'd0);
    check("issue_count", 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check("issue_word", 32'(got_q[i]), 32'(exp_q[i]));
    check("start_count", 32'(start_cnt), 32'(exp_q.size()));
    check("frame_err_count", 32'(err_cnt), 32'(exp_err));
    got_q.delete();
    exp_q.delete();
    start_cnt = 0;
    err_cnt   = 0;
    exp_err   = 0;
  endtask

  initial begin
    logic [31:0] bits;
    logic [15:0] word;
    int n, r;

    reset = 1'b1; spi_sclk = 1'b0; spi_cs_n = 1'b1; spi_mosi = 1'b0; cpu_out = 8'h00;
    wait_clk(3);
    check("rst_opcode", 32'(opcode), 32'd0);
    check("rst_operand", 32'(operand), 32'd0);
    check("rst_start", 32'(start), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_miso", 32'(spi_miso), 32'd0);
    reset = 1'b0;
    wait_clk(10);

    // Basic frame with reply 0xC3; then short frame followed by a good one
    send_frame(32'h11A5, 16, 8'hC3, 2 * HALF);
    verify();
    send_frame(32'h0155, 9, 8'h5A, 2 * HALF);
    verify();
    send_frame(32'h2B3C, 16, 8'h81, 2 * HALF);
    verify();

    // Over-long frame: only the first 16 bits count
    send_frame(32'hABCDE, 20, 8'hF0, 2 * HALF);
    verify();

    // Reset mid-frame with CS held low, then a normal frame
    cpu_out  = 8'h77;
    spi_cs_n = 1'b0;
    wait_clk(2 * HALF);
    clock_bits(32'h3FF, 10, 8'h77, 1'b1);
    reset = 1'b1;
    wait_clk(2);
    reset = 1'b0;
    wait_clk(4);
    clock_bits(32'h2AA, 10, 8'h00, 1'b0);
    wait_clk(HALF);
    spi_cs_n = 1'b1;
    verify();
    send_frame(32'h4D21, 16, 8'h3C, 2 * HALF);
    verify();

    // Back-to-back frames, one SCLK period of CS-high gap
    send_frame(32'h5A01, 16, 8'h12, 2 * HALF);
    send_frame(32'h6B02, 16, 8'h34, 2 * HALF);
    verify();

    // Randomized frames
    for (int k = 0; k < 40; k++) begin
      r = int'($urandom_range(0, 9));
      if (r < 6)      n = 16;
      else if (r < 8) n = int'($urandom_range(1, 15));
      else            n = int'($urandom_range(17, 20));
      if (n >= 16) begin
        word = {8'($urandom_range(1, 255)), 8'($urandom)};
        bits = (32'(word) << (n - 16)) | (32'($urandom) & ((32'd1 << (n - 16)) - 32'd1));
      end else begin
        bits = 32'($urandom) & ((32'd1 << n) - 32'd1);
      end
      send_frame(bits, n, 8'($urandom), HALF * int'($urandom_range(2, 6)));
      if (k % 3 == 2) verify();
    end
    verify();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
